// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared state type, widths and helpers for the cache port arbiter
// Contents: state_t (controller states), default ADDR_W/DATA_W, STAT_W,
//           sat_inc (saturating increment for the statistics counters).
package cache_ctrl_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;
    localparam int STAT_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL,
        ST_RESP
    } state_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin selector
// Ports: req       - request vector
//        ptr       - index of the highest-priority requester this round
//        grant     - one-hot winner (all zero when no request)
//        grant_idx - binary index of the winner (0 when no request)
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    // Walk the requesters starting at ptr, wrapping once; the first set bit wins.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        logic             found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = cand[IDX_W-1:0];
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - round-robin arbiter sharing one cache port among NUM_REQ requesters
// Ports: clk, reset_n (async, active-low)
//        req_valid/req_ready/req_addr/req_write/req_wdata - requester side, packed per requester
//        resp_valid/resp_hit/resp_rdata                   - one-hot completion strobe and result
//        cache_en/cache_address/cache_is_write/cache_write_data - cache request, cache_en for one cycle
//        cache_hit/cache_read_data                        - combinational cache lookup result
//        stat_hits/stat_misses                            - saturating access counters
module cache_port_arbiter
    import cache_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic                      resp_hit,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      cache_en,
    output logic [ADDR_W-1:0]         cache_address,
    output logic                      cache_is_write,
    output logic [DATA_W-1:0]         cache_write_data,
    input  logic                      cache_hit,
    input  logic [DATA_W-1:0]         cache_read_data,
    output logic [STAT_W-1:0]         stat_hits,
    output logic [STAT_W-1:0]         stat_misses
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_grant;
    logic               accept;

    logic [ADDR_W-1:0]  addr_q;
    logic               write_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               hit_q;
    logic [DATA_W-1:0]  data_q;
    logic [STAT_W-1:0]  hits_q;
    logic [STAT_W-1:0]  misses_q;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (win_grant),
        .grant_idx (win_idx)
    );

    // Gated by reset_n so no requester sees a ready strobe while reset is held.
    assign accept = reset_n && (state == ST_IDLE) && (req_valid != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        resp_valid = '0;
        cache_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    req_ready  = win_grant;
                    state_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                cache_en   = 1'b1;
                state_next = (cache_hit || write_q) ? ST_RESP : ST_FILL;
            end
            ST_FILL: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid[owner] = 1'b1;
                state_next        = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr   <= '0;
            owner    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            hit_q    <= 1'b0;
            data_q   <= '0;
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner   <= win_idx;
                        addr_q  <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                        write_q <= req_write[win_idx];
                        wdata_q <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
                    end
                end
                ST_LOOKUP: begin
                    hit_q  <= cache_hit;
                    // Writes return zero data regardless of what the cache presents.
                    data_q <= write_q ? '0 : cache_read_data;
                    if (cache_hit) begin
                        hits_q <= sat_inc(hits_q);
                    end else begin
                        misses_q <= sat_inc(misses_q);
                    end
                end
                ST_FILL: begin
                    // The cache has completed its fill by now; take the refilled data.
                    data_q <= cache_read_data;
                end
                ST_RESP: begin
                    rr_ptr <= (int'(owner) == NUM_REQ - 1) ? '0 : owner + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // The cache request registers only change on acceptance, so they hold
    // their values outside LOOKUP.
    assign cache_address    = addr_q;
    assign cache_is_write   = write_q;
    assign cache_write_data = wdata_q;

    assign resp_hit    = (state == ST_RESP) && hit_q;
    assign resp_rdata  = (state == ST_RESP) ? data_q : '0;
    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - self-checking bench for cache_port_arbiter
module tb_cache_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR-1:0]    req_write = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR-1:0]    resp_valid;
    logic             resp_hit;
    logic [DW-1:0]    resp_rdata;
    logic             cache_en;
    logic [AW-1:0]    cache_address;
    logic             cache_is_write;
    logic [DW-1:0]    cache_write_data;
    logic             cache_hit;
    logic [DW-1:0]    cache_read_data;
    logic [15:0]      stat_hits;
    logic [15:0]      stat_misses;

    cache_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_write        (req_write),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_hit         (resp_hit),
        .resp_rdata       (resp_rdata),
        .cache_en         (cache_en),
        .cache_address    (cache_address),
        .cache_is_write   (cache_is_write),
        .cache_write_data (cache_write_data),
        .cache_hit        (cache_hit),
        .cache_read_data  (cache_read_data),
        .stat_hits        (stat_hits),
        .stat_misses      (stat_misses)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Cache model: write-allocate, read miss fills from mem_val on the enable edge.
    logic [31:0] cdata [logic [31:0]];
    int          model_ver = 0;
    logic [31:0] pa;
    logic [31:0] pd;
    logic        pw;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    always @(cache_address or model_ver) begin
        cache_hit       = (cdata.exists(cache_address) != 0);
        cache_read_data = (cdata.exists(cache_address) != 0) ? cdata[cache_address]
                                                              : (32'hBAD0_0000 ^ cache_address);
    end

    always begin
        @(negedge clk);
        if (cache_en === 1'b1) begin
            pa = cache_address;
            pw = cache_is_write;
            pd = cache_write_data;
            @(posedge clk);
            #1;
            if (pw) cdata[pa] = pd;
            else if (cdata.exists(pa) == 0) cdata[pa] = mem_val(pa);
            model_ver = model_ver + 1;
        end
    end

    // Reference arbiter/counter state.
    int m_rr = 0;
    int m_hits = 0;
    int m_misses = 0;

    // Per-requester stimulus and observed transaction results.
    logic [31:0] t_addr  [NR];
    logic        t_write [NR];
    logic [31:0] t_wdata [NR];
    int          r_g, r_acc, r_lat, r_owner, r_en;
    logic        r_hit, r_en_wr;
    logic [31:0] r_rdata, r_en_addr, r_en_wd;
    bit          r_bad, r_to;

    function automatic int first_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int exp_grant(input logic [NR-1:0] mask, input int rr);
        for (int k = 0; k < NR; k++) if (mask[(rr + k) % NR]) return (rr + k) % NR;
        return -1;
    endfunction

    // Drives one transaction attempt and records what the DUT did.
    task automatic issue(input logic [NR-1:0] mask, input bit hold);
        bit acc;
        bit done;
        int c;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = t_addr[i];
            req_write[i]          = t_write[i];
            req_wdata[i*DW +: DW] = t_wdata[i];
        end
        r_g = -1; r_acc = -1; r_lat = -1; r_owner = -1; r_en = 0;
        r_hit = 1'bx; r_rdata = 'x; r_en_addr = 'x; r_en_wr = 1'bx; r_en_wd = 'x;
        r_bad = 1'b0; acc = 1'b0; done = 1'b0; c = 0;
        while (!done && c < 30) begin
            @(negedge clk);
            if (!acc) req_valid = mask;
            else if (!hold) req_valid = '0;
            #1;
            if (req_ready != '0) begin
                if (acc || $countones(req_ready) != 1 || (req_ready & ~mask) != '0) r_bad = 1'b1;
                if (!acc) begin
                    acc   = 1'b1;
                    r_acc = c;
                    r_g   = first_idx(req_ready);
                end
            end
            if (cache_en === 1'b1) begin
                r_en++;
                r_en_addr = cache_address;
                r_en_wr   = cache_is_write;
                r_en_wd   = cache_write_data;
            end
            if (resp_valid != '0) begin
                if (!acc || $countones(resp_valid) != 1) r_bad = 1'b1;
                done    = 1'b1;
                r_lat   = c - r_acc;
                r_owner = first_idx(resp_valid);
                r_hit   = resp_hit;
                r_rdata = resp_rdata;
            end
            c++;
        end
        r_to = !done;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_valid = '1;
        req_write = '1;
        req_addr = '1;
        req_wdata = '1;
        model_ver = model_ver + 1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (req_ready !== '0) $display("FAIL rst_ready: got %0h want 0", req_ready); else n_pass++;
        n_checks++; if (resp_valid !== '0) $display("FAIL rst_resp_valid: got %0h want 0", resp_valid); else n_pass++;
        n_checks++; if (resp_hit !== 1'b0) $display("FAIL rst_resp_hit: got %0h want 0", resp_hit); else n_pass++;
        n_checks++; if (resp_rdata !== '0) $display("FAIL rst_resp_rdata: got %0h want 0", resp_rdata); else n_pass++;
        n_checks++; if (cache_en !== 1'b0) $display("FAIL rst_cache_en: got %0h want 0", cache_en); else n_pass++;
        n_checks++; if (cache_address !== '0) $display("FAIL rst_cache_addr: got %0h want 0", cache_address); else n_pass++;
        n_checks++; if (cache_is_write !== 1'b0) $display("FAIL rst_cache_wr: got %0h want 0", cache_is_write); else n_pass++;
        n_checks++; if (cache_write_data !== '0) $display("FAIL rst_cache_wd: got %0h want 0", cache_write_data); else n_pass++;
        n_checks++; if (stat_hits !== 16'h0) $display("FAIL rst_hits: got %0h want 0", stat_hits); else n_pass++;
        n_checks++; if (stat_misses !== 16'h0) $display("FAIL rst_misses: got %0h want 0", stat_misses); else n_pass++;
        @(negedge clk);
        req_valid = '0;
        req_write = '0;
        reset_n = 1'b1;
        m_rr = 0; m_hits = 0; m_misses = 0;
    endtask

    task automatic test_read_miss();
        t_addr[0] = 32'h40; t_write[0] = 1'b0; t_wdata[0] = 32'h0;
        issue(2'b01, 1'b0);
        m_misses++; m_rr = 1;
        n_checks++; if (r_to || r_bad) $display("FAIL miss_protocol: got to=%0d bad=%0d want 0 0", r_to, r_bad); else n_pass++;
        n_checks++; if (r_g !== 0 || r_owner !== 0) $display("FAIL miss_owner: got g=%0d o=%0d want 0 0", r_g, r_owner); else n_pass++;
        n_checks++; if (r_lat !== 3) $display("FAIL miss_latency: got %0d want 3", r_lat); else n_pass++;
        n_checks++; if (r_hit !== 1'b0) $display("FAIL miss_hit: got %0h want 0", r_hit); else n_pass++;
        n_checks++; if (r_rdata !== 32'hDEADBEEF) $display("FAIL miss_rdata: got %0h want deadbeef", r_rdata); else n_pass++;
        n_checks++; if (stat_misses !== 16'd1 || stat_hits !== 16'd0) $display("FAIL miss_stats: got h=%0d m=%0d want 0 1", stat_hits, stat_misses); else n_pass++;
        n_checks++; if (r_en !== 1 || r_en_addr !== 32'h40 || r_en_wr !== 1'b0) $display("FAIL miss_cache_req: got en=%0d a=%0h w=%0h want 1 40 0", r_en, r_en_addr, r_en_wr); else n_pass++;
    endtask

    task automatic test_read_hit();
        t_addr[0] = 32'h40; t_write[0] = 1'b0;
        issue(2'b01, 1'b0);
        m_hits++; m_rr = 1;
        n_checks++; if (r_to || r_bad) $display("FAIL hit_protocol: got to=%0d bad=%0d want 0 0", r_to, r_bad); else n_pass++;
        n_checks++; if (r_lat !== 2) $display("FAIL hit_latency: got %0d want 2", r_lat); else n_pass++;
        n_checks++; if (r_hit !== 1'b1) $display("FAIL hit_hit: got %0h want 1", r_hit); else n_pass++;
        n_checks++; if (r_rdata !== 32'hDEADBEEF) $display("FAIL hit_rdata: got %0h want deadbeef", r_rdata); else n_pass++;
        n_checks++; if (stat_hits !== 16'd1 || stat_misses !== 16'd1) $display("FAIL hit_stats: got h=%0d m=%0d want 1 1", stat_hits, stat_misses); else n_pass++;
        n_checks++; if (r_en !== 1) $display("FAIL hit_cache_en_cycles: got %0d want 1", r_en); else n_pass++;
    endtask

    task automatic test_write_read();
        t_addr[1] = 32'h80; t_write[1] = 1'b1; t_wdata[1] = 32'h12345678;
        issue(2'b10, 1'b0);
        m_misses++; m_rr = 0;
        n_checks++; if (r_to || r_bad || r_owner !== 1) $display("FAIL wr_protocol: got to=%0d bad=%0d o=%0d want 0 0 1", r_to, r_bad, r_owner); else n_pass++;
        n_checks++; if (r_lat !== 2) $display("FAIL wr_latency: got %0d want 2", r_lat); else n_pass++;
        n_checks++; if (r_rdata !== 32'h0) $display("FAIL wr_rdata: got %0h want 0", r_rdata); else n_pass++;
        n_checks++; if (r_en_wr !== 1'b1 || r_en_wd !== 32'h12345678 || r_en_addr !== 32'h80) $display("FAIL wr_cache_req: got w=%0h d=%0h a=%0h want 1 12345678 80", r_en_wr, r_en_wd, r_en_addr); else n_pass++;
        t_addr[0] = 32'h80; t_write[0] = 1'b0;
        issue(2'b01, 1'b0);
        m_hits++; m_rr = 1;
        n_checks++; if (r_hit !== 1'b1 || r_lat !== 2) $display("FAIL rd_after_wr_hit: got hit=%0h lat=%0d want 1 2", r_hit, r_lat); else n_pass++;
        n_checks++; if (r_rdata !== 32'h12345678) $display("FAIL rd_after_wr_rdata: got %0h want 12345678", r_rdata); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int prev;
        int eg;
        prev = -1;
        for (int i = 0; i < NR; i++) begin
            t_addr[i] = 32'h40; t_write[i] = 1'b0;
        end
        for (int n = 0; n < 6; n++) begin
            eg = exp_grant(2'b11, m_rr);
            issue(2'b11, 1'b1);
            m_hits++;
            n_checks++; if (r_to || r_bad || r_g !== eg || r_owner !== eg) $display("FAIL b2b_grant: got g=%0d o=%0d to=%0d bad=%0d want %0d", r_g, r_owner, r_to, r_bad, eg); else n_pass++;
            n_checks++; if (r_g === prev) $display("FAIL b2b_repeat: got %0d twice want alternating", r_g); else n_pass++;
            n_checks++; if (r_acc !== 0) $display("FAIL b2b_accept_delay: got %0d want 0", r_acc); else n_pass++;
            prev = r_g;
            m_rr = (eg + 1) % NR;
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_fill();
        int spurious;
        t_addr[0] = 32'h200; t_write[0] = 1'b0;
        req_addr[0 +: AW] = t_addr[0];
        req_write[0] = 1'b0;
        @(negedge clk);
        req_valid = 2'b01;
        #1;
        n_checks++; if (req_ready !== 2'b01) $display("FAIL rmf_accept: got %0h want 1", req_ready); else n_pass++;
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (cache_en !== 1'b1) $display("FAIL rmf_lookup_en: got %0h want 1", cache_en); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (cache_en !== 1'b0) $display("FAIL rmf_fill_en: got %0h want 0", cache_en); else n_pass++;
        reset_n = 1'b0;
        #1;
        spurious = 0;
        for (int c = 0; c < 4; c++) begin
            if (resp_valid != '0) spurious++;
            @(negedge clk);
            #1;
        end
        n_checks++; if (spurious !== 0) $display("FAIL rmf_no_resp: got %0d responses want 0", spurious); else n_pass++;
        n_checks++; if (stat_hits !== 16'd0 || stat_misses !== 16'd0) $display("FAIL rmf_stats: got h=%0d m=%0d want 0 0", stat_hits, stat_misses); else n_pass++;
        reset_n = 1'b1;
        m_rr = 0; m_hits = 0; m_misses = 0;
        t_addr[1] = 32'h300; t_write[1] = 1'b0;
        issue(2'b11, 1'b0);
        m_hits++; m_rr = 1;
        n_checks++; if (r_to || r_bad || r_g !== 0 || r_acc !== 0) $display("FAIL rmf_next_grant: got g=%0d acc=%0d to=%0d want 0 0 0", r_g, r_acc, r_to); else n_pass++;
        n_checks++; if (r_hit !== 1'b1 || r_lat !== 2 || r_rdata !== mem_val(32'h200)) $display("FAIL rmf_next_resp: got hit=%0h lat=%0d d=%0h want 1 2 %0h", r_hit, r_lat, r_rdata, mem_val(32'h200)); else n_pass++;
        n_checks++; if (stat_hits !== 16'd1 || stat_misses !== 16'd0) $display("FAIL rmf_next_stats: got h=%0d m=%0d want 1 0", stat_hits, stat_misses); else n_pass++;
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut.hits_q = 16'hFFFD;
        @(negedge clk);
        release dut.hits_q;
        m_hits = 16'hFFFD;
        #1;
        n_checks++; if (stat_hits !== 16'hFFFD) $display("FAIL sat_preset: got %0h want fffd", stat_hits); else n_pass++;
        t_addr[0] = 32'h40; t_write[0] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            issue(2'b01, 1'b0);
            if (m_hits != 16'hFFFF) m_hits++;
            m_rr = 1;
            n_checks++; if (stat_hits !== 16'(m_hits) || r_hit !== 1'b1) $display("FAIL sat_hits: got %0h hit=%0h want %0h 1", stat_hits, r_hit, 16'(m_hits)); else n_pass++;
        end
        n_checks++; if (stat_misses !== 16'(m_misses)) $display("FAIL sat_misses: got %0h want %0h", stat_misses, 16'(m_misses)); else n_pass++;
    endtask

    task automatic test_random();
        logic [NR-1:0] mask;
        int            eg;
        int            el;
        logic          eh;
        logic [31:0]   ea;
        logic [31:0]   ed;
        logic          ew;
        for (int n = 0; n < 40; n++) begin
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) begin
                t_addr[i]  = 32'h1000 + ($urandom_range(0, 7) << 4);
                t_write[i] = ($urandom_range(0, 3) == 0);
                t_wdata[i] = $urandom;
            end
            eg = exp_grant(mask, m_rr);
            ea = t_addr[eg];
            ew = t_write[eg];
            eh = (cdata.exists(ea) != 0);
            ed = ew ? 32'h0 : (eh ? cdata[ea] : mem_val(ea));
            el = (eh || ew) ? 2 : 3;
            if (eh) begin
                if (m_hits != 16'hFFFF) m_hits++;
            end else begin
                if (m_misses != 16'hFFFF) m_misses++;
            end
            issue(mask, 1'b0);
            n_checks++; if (r_to || r_bad || r_g !== eg || r_owner !== eg) $display("FAIL rnd_grant[%0d]: got g=%0d o=%0d to=%0d bad=%0d want %0d", n, r_g, r_owner, r_to, r_bad, eg); else n_pass++;
            n_checks++; if (r_lat !== el || r_hit !== eh) $display("FAIL rnd_timing[%0d]: got lat=%0d hit=%0h want %0d %0h", n, r_lat, r_hit, el, eh); else n_pass++;
            n_checks++; if (r_rdata !== ed) $display("FAIL rnd_rdata[%0d]: got %0h want %0h", n, r_rdata, ed); else n_pass++;
            n_checks++; if (r_en !== 1 || r_en_addr !== ea || r_en_wr !== ew) $display("FAIL rnd_cache_req[%0d]: got en=%0d a=%0h w=%0h want 1 %0h %0h", n, r_en, r_en_addr, r_en_wr, ea, ew); else n_pass++;
            n_checks++; if (stat_hits !== 16'(m_hits) || stat_misses !== 16'(m_misses)) $display("FAIL rnd_stats[%0d]: got h=%0h m=%0h want %0h %0h", n, stat_hits, stat_misses, 16'(m_hits), 16'(m_misses)); else n_pass++;
            m_rr = (eg + 1) % NR;
        end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_read();
        test_back_to_back();
        test_reset_mid_fill();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_port_arbiter.md
CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, 2, number of requesters sharing the cache (legal 2..4).
REQ-002 Parameter ADDR_W, 32, request address width.
REQ-003 Parameter DATA_W, 32, request data width.
REQ-004 Port clk  input  1  the single clock; all state changes on posedge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 Port req_ready  output  NUM_REQ  one-hot accept strobe.
REQ-008 Port req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at slice i.
REQ-009 Port req_write  input  NUM_REQ  1 = write, 0 = read.
REQ-010 Port req_wdata  input  NUM_REQ*DATA_W  packed write data.
REQ-011 Port resp_valid  output  NUM_REQ  one-hot completion strobe.
REQ-012 Port resp_hit  output  1  hit status of the completed access.
REQ-013 Port resp_rdata  output  DATA_W  read data; 0 for writes.
REQ-014 Port cache_en  output  1  cache state advances only on posedges where cache_en=1.
REQ-015 Port cache_address / cache_is_write / cache_write_data  output  ADDR_W/1/DATA_W  cache request.
REQ-016 Port cache_hit / cache_read_data  input  1/DATA_W  combinational cache lookup result.
REQ-017 Port stat_hits / stat_misses  output  16/16  saturating access counters.

Function
REQ-018 FSM states IDLE, LOOKUP, FILL, RESP; transitions only on posedge clk.
REQ-019 IDLE: if any req_valid, grant round-robin winner w (first set bit at or after rr_ptr, wrapping), assert req_ready[w] combinationally that cycle, latch addr/write/wdata and owner=w, go LOOKUP; else stay IDLE, rr_ptr unchanged.
REQ-020 A request is accepted only when req_valid[i] and req_ready[i] are both 1; deasserting req_valid before acceptance is legal and has no effect.
REQ-021 LOOKUP: drive latched request on cache_*, cache_en=1 for exactly this cycle; capture cache_hit as hit_q and cache_read_data.
REQ-022 LOOKUP -> RESP if hit or write; LOOKUP -> FILL if read miss.
REQ-023 FILL: hold cache_address, cache_en=0, capture cache_read_data (post-fill value); go RESP.
REQ-024 RESP: resp_valid[owner]=1 for one cycle, resp_hit=hit_q, resp_rdata=captured data (0 for writes); rr_ptr <= (owner+1) mod NUM_REQ; go IDLE.
REQ-025 Latency from accept cycle T: response at T+2 for hits and writes, T+3 for read misses; at most one request in flight.
REQ-026 cache_en=0 in IDLE, FILL, RESP; cache_address/cache_is_write/cache_write_data hold their last values outside LOOKUP.
REQ-027 In LOOKUP, stat_hits increments if cache_hit else stat_misses increments; both saturate at 16'hFFFF.
REQ-028 req_ready and resp_valid are zero outside IDLE and RESP respectively, and never have more than one bit set.

Reset
REQ-029 reset_n low asynchronously forces state IDLE, rr_ptr=0, owner=0, all latches and counters 0.
REQ-030 During/after reset: req_ready=0, resp_valid=0, resp_hit=0, resp_rdata=0, cache_en=0, cache_* outputs 0.
REQ-031 Reset mid-transaction aborts it; no resp_valid is issued for the aborted request.

Structure
REQ-032 Shared package cache_ctrl_pkg holds the state enum and the DATA_W/ADDR_W defaults.
REQ-033 Round-robin selection is a sub-module rr_arbiter (inputs req, ptr; outputs one-hot grant, grant index).

Verification
REQ-034 Single read miss, addr 0x40, memory 0xDEADBEEF -> resp at T+3, resp_hit=0, rdata=0xDEADBEEF, stat_misses=1.
REQ-035 Repeat same read -> resp at T+2, resp_hit=1, rdata=0xDEADBEEF, stat_hits=1, cache_en high exactly one cycle per access.
REQ-036 Write 0x12345678 to 0x80 then read 0x80 -> write resp_rdata=0, read resp_hit=1, rdata=0x12345678.
REQ-037 Both requesters valid continuously, NUM_REQ=2 -> grants alternate 0,1,0,1; no requester granted twice in a row.
REQ-038 reset_n low during FILL -> no resp_valid, state IDLE, counters 0; next request completes normally.
REQ-039 Force stat_hits to 0xFFFF via repeated hits -> further hits leave stat_hits at 0xFFFF.
